// File: rtl/w5300_bus_master.sv
// Bus initiator for the W5300 parallel interface: timed cs/rd/wr cycles,
// chip reset pulse generation and a sticky, synchronized interrupt request.
module w5300_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned RST_CYC    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rnw,
  input  logic [9:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       ack,
  input  logic       int_clr,
  output logic       int_req,
  output logic [9:0] w_addr,
  output logic       w_cs_n,
  output logic       w_rd_n,
  output logic       w_wr_n,
  output logic       w_rst_n,
  input  logic       w_int_n,
  inout  wire  [7:0] w_d
);

  typedef enum logic [2:0] {
    RESET, IDLE, SETUP, STROBE, HOLD
  } state_e;

  localparam logic [7:0] RST_LAST = 8'(RST_CYC - 1);
  localparam logic [7:0] SET_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STB_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HLD_LAST = 8'(HOLD_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rnw_q, rnw_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] wd_q, wd_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       oe_q, oe_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rst_n_q, rst_n_d;
  logic [2:0] sync_q;
  logic       int_q, int_d;
  logic       active;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    rst_n_d = rst_n_q;
    unique case (state_q)
      RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = IDLE;
          rst_n_d = 1'b1;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          state_d = SETUP;
          rnw_d   = rnw;
          addr_d  = addr;
          wd_d    = wdata;
        end
      end
      SETUP: begin
        if (cnt_q == SET_LAST) begin
          state_d = STROBE;
          cnt_d   = '0;
        end
      end
      STROBE: begin
        if (cnt_q == STB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          if (rnw_q) rdata_d = w_d;
        end
      end
      HOLD: begin
        if (cnt_q == HLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end
      end
      default: begin
        state_d = RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Pins are registered from the next state so they switch cleanly
  always_comb begin
    active = (state_d == SETUP) || (state_d == STROBE)
          || (state_d == HOLD);
    cs_n_d = !active;
    rd_n_d = !((state_d == STROBE) && rnw_d);
    wr_n_d = !((state_d == STROBE) && !rnw_d);
    oe_d   = active && !rnw_d;
    busy_d = (state_d != IDLE);
    int_d  = (sync_q[2] && !sync_q[1]) || (int_q && !int_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET;
      cnt_q   <= '0;
      rnw_q   <= 1'b1;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      oe_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rst_n_q <= 1'b0;
      sync_q  <= 3'b111;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      oe_q    <= oe_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      rst_n_q <= rst_n_d;
      sync_q  <= {sync_q[1:0], w_int_n};
      int_q   <= int_d;
    end
  end

  assign w_d     = oe_q ? wd_q : 'z;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign ack     = ack_q;
  assign int_req = int_q;
  assign w_addr  = addr_q;
  assign w_cs_n  = cs_n_q;
  assign w_rd_n  = rd_n_q;
  assign w_wr_n  = wr_n_q;
  assign w_rst_n = rst_n_q;

endmodule
